// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// hz_state_t tracks whether any cache request is still outstanding.
package types;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_t;

  localparam int unsigned NUM_PERF = 4;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Load-enable/flush generator: freezes the pipeline until all cache requests respond.
// Define PIPE_PERF_EN to build the four saturating performance counters.
module pipeline_stall_ctrl
  import types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic        dmem_resp,
  input  logic        br_redirect,
  output logic        imem_read_gated,
  output logic        dmem_read_gated,
  output logic        dmem_write_gated,
  output logic        pc_ld,
  output logic        ifid_ld,
  output logic        idex_ld,
  output logic        exmem_ld,
  output logic        memwb_ld,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [31:0] stall_cycles,
  output logic [31:0] istall_cycles,
  output logic [31:0] dstall_cycles,
  output logic [31:0] flush_count
);

  hz_state_t state_q, state_d;
  logic      i_done_q, i_done_d;
  logic      d_done_q, d_done_d;
  logic      redirect_pend_q, redirect_pend_d;
  logic      i_done_eff, d_done_eff;
  logic      i_ok, d_ok, advance, flush;

  // Done flags can only be set while stalled, so qualifying them with WAIT is free.
  assign i_done_eff = i_done_q && (state_q == WAIT);
  assign d_done_eff = d_done_q && (state_q == WAIT);

  assign i_ok    = !imem_read || imem_resp || i_done_eff;
  assign d_ok    = !(dmem_read || dmem_write) || dmem_resp || d_done_eff;
  assign advance = i_ok && d_ok;
  assign flush   = advance && (br_redirect || redirect_pend_q);

  always_comb begin
    state_d          = state_q;
    i_done_d         = i_done_q;
    d_done_d         = d_done_q;
    redirect_pend_d  = redirect_pend_q;
    pc_ld            = 1'b0;
    ifid_ld          = 1'b0;
    idex_ld          = 1'b0;
    exmem_ld         = 1'b0;
    memwb_ld         = 1'b0;
    ifid_flush       = 1'b1;
    idex_flush       = 1'b1;
    imem_read_gated  = 1'b0;
    dmem_read_gated  = 1'b0;
    dmem_write_gated = 1'b0;

    if (advance) begin
      state_d         = RUN;
      i_done_d        = 1'b0;
      d_done_d        = 1'b0;
      redirect_pend_d = 1'b0;
    end else begin
      state_d         = WAIT;
      i_done_d        = i_done_q || imem_resp;
      d_done_d        = d_done_q || dmem_resp;
      redirect_pend_d = redirect_pend_q || br_redirect;
    end

    if (!rst) begin
      pc_ld            = advance;
      ifid_ld          = advance;
      idex_ld          = advance;
      exmem_ld         = advance;
      memwb_ld         = advance;
      ifid_flush       = flush;
      idex_flush       = flush;
      imem_read_gated  = imem_read && !i_done_eff;
      dmem_read_gated  = dmem_read && !d_done_eff;
      dmem_write_gated = dmem_write && !d_done_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= RUN;
      i_done_q        <= 1'b0;
      d_done_q        <= 1'b0;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      i_done_q        <= i_done_d;
      d_done_q        <= d_done_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [NUM_PERF-1:0] perf_inc;
  logic [31:0]         perf_cnt [NUM_PERF];

  assign perf_inc = {flush, !d_ok, !i_ok, !advance};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PERF; gi++) begin : g_perf
      sat_counter32 u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (perf_inc[gi]),
        .count (perf_cnt[gi])
      );
    end
  endgenerate

  assign stall_cycles  = perf_cnt[0];
  assign istall_cycles = perf_cnt[1];
  assign dstall_cycles = perf_cnt[2];
  assign flush_count   = perf_cnt[3];
`else
  assign stall_cycles  = 32'h0;
  assign istall_cycles = 32'h0;
  assign dstall_cycles = 32'h0;
  assign flush_count   = 32'h0;
`endif

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Generates the load-enable and flush controls that write the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. The forwarding units only read those registers. This block decides when they advance. It stalls the whole pipeline until every outstanding I-cache and D-cache request has responded. It also converts a taken-branch redirect from EX into a bubble in IF/ID and ID/EX, and holds that redirect across a stall if necessary.

## Interface
- No parameters.
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- imem_read  input  1  IF stage is requesting an instruction
- imem_resp  input  1  I-cache response valid (one-cycle pulse)
- dmem_read  input  1  MEM stage load request
- dmem_write  input  1  MEM stage store request
- dmem_resp  input  1  D-cache response valid (one-cycle pulse)
- br_redirect  input  1  EX resolved a taken branch or jump; PC mux already selects the target
- imem_read_gated  output  1  imem_read masked once its response is latched
- dmem_read_gated / dmem_write_gated  output  1 each  the D-cache requests, masked the same way
- pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld  output  1 each  pipeline register load enables
- ifid_flush, idex_flush  output  1 each  load a NOP/bubble instead of the stage input
- stall_cycles, istall_cycles, dstall_cycles, flush_count  output  32 each  performance counters

## Operation
- State register `hz_state_t`:
  - RUN: no request is pending, or the pending request completes this cycle.
  - WAIT: at least one request is outstanding.
- Done flags `i_done` and `d_done` latch when `imem_resp` or `dmem_resp` arrives while a stall persists because of the other side.
- `i_ok = !imem_read | imem_resp | i_done`
- `d_ok = !(dmem_read|dmem_write) | dmem_resp | d_done`
- `advance = i_ok & d_ok`
- Load enables:
  - `pc_ld`, `ifid_ld`, `idex_ld`, `exmem_ld` and `memwb_ld` all equal `advance`.
  - A stall freezes the whole pipeline. There is no partial advance.
- On a non-advancing cycle:
  - If `imem_resp` is seen, set `i_done`.
  - If `dmem_resp` is seen, set `d_done`.
  - If `br_redirect` is seen, set `redirect_pend`.
- On an advancing cycle, clear `i_done`, `d_done` and `redirect_pend`.
- Gated requests:
  - `imem_read_gated = imem_read & !i_done`
  - The D-cache side is gated the same way with `d_done`.
  - Gating prevents a completed access from being re-issued.
- Flushes:
  - `ifid_flush = idex_flush = advance & (br_redirect | redirect_pend)`.
  - A redirect always waits for the in-flight wrong-path fetch response, because the cache cannot abort a request.
- Next state: WAIT when `!advance`, otherwise RUN.
- Simultaneous events:
  - Both responses arriving in the same cycle gives a single advance.
  - A response arriving in the same cycle as `br_redirect` advances and flushes in that cycle.
- Reset:
  - Forces RUN, clears all flags and counters, and takes priority over every other input.
  - While `rst` is high, all `*_ld` are 0, both flushes are 1 and the gated requests are 0.

## Timing
- Combinational paths: from the `*_resp` inputs to `*_ld` and the flushes.
- Zero added latency on a cache hit: a response in cycle N advances in cycle N.
- Flags, state and counters update on the `clk` edge. Their effect on the outputs is visible in cycle N+1.
- Request and redirect inputs must be held stable by the frozen pipeline while stalled. The bench checks this.

## Configuration
- `PIPE_PERF_EN` defined: the four 32-bit counters are active and saturate at 32'hFFFF_FFFF.
  - `stall_cycles` increments on every cycle with `!advance`.
  - `istall_cycles` increments when `!i_ok`.
  - `dstall_cycles` increments when `!d_ok`.
  - `flush_count` increments on each `ifid_flush` pulse.
- `PIPE_PERF_EN` undefined: the ports remain, tied to 32'h0. No counter flops are synthesized.

## Structure
- The `types` package holds `hz_state_t` (RUN, WAIT).
- The `rv32i_types` package is not extended.
- One sub-module, `sat_counter32`, instanced four times under `PIPE_PERF_EN`. Its ports are clk, rst, inc and count.

## Test plan
- Both caches hit (`imem_resp=1` and `dmem_resp=1` in the same cycle): every `*_ld` is 1 each cycle, no flush, `stall_cycles` stays 0.
- I-miss: `imem_resp` arrives 5 cycles after the request, with no D-cache request. Required response:
  - All loads are 0 for 5 cycles, then 1.
  - `istall_cycles` = 5, `stall_cycles` = 5.
- `imem_resp` at cycle 2 and `dmem_resp` at cycle 6:
  - `i_done` sets and `imem_read_gated` drops from cycle 3.
  - Advance occurs at cycle 6.
  - `istall_cycles` = 2, `dstall_cycles` = 6, `stall_cycles` = 6.
- `br_redirect` asserted during a 3-cycle D-miss: no flush until `dmem_resp`. On that cycle both flushes and all loads are 1 and `flush_count` = 1.
- `br_redirect` coincides with an I-cache hit: the flush and the advance happen in the same cycle.
- `rst` asserted mid-stall with `i_done` set:
  - During reset: loads are 0 and flushes are 1.
  - The cycle after reset deasserts: flags and counters are 0 and state is RUN.
